// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port data RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        MEM_BYTE = 3'b000,
        MEM_HALF = 3'b001,
        MEM_WORD = 3'b010
    } mem_size_e;

    typedef logic owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/ram_arb_access_check.sv
// Combinational legality check of one access: alignment, size encoding and RAM range.
module ram_arb_access_check
    import ram_arb_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 8001
) (
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    output logic        legal_o
);

    logic align_ok;
    logic in_range;

    always_comb begin
        align_ok = 1'b0;
        case (size_i)
            MEM_BYTE: align_ok = 1'b1;
            MEM_HALF: align_ok = ~addr_i[0];
            MEM_WORD: align_ok = (addr_i[1:0] == 2'b00);
            default:  align_ok = 1'b0;
        endcase
        in_range = ({2'b00, addr_i[31:2]} < 32'(RAM_WORDS));
        legal_o  = align_ok & in_range;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the shared data RAM with a one-cycle read response path.
// Optional access checking is enabled with the RAM_ARB_ACCESS_CHECK_EN macro.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned RAM_WORDS = 8001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        boot_active,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
`ifdef RAM_ARB_ACCESS_CHECK_EN
    output logic        m0_err,
    output logic        m1_err,
`endif
    output logic        ram_we,
    output logic        ram_re,
    output logic [2:0]  ram_size,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    owner_t     last_gnt_q, last_gnt_d;
    rsp_state_e state_q;
    owner_t     rd_owner_q;
    logic       rd_err_q;

    logic        legal0, legal1;
    logic        win0, any_gnt, rd_gnt, drive;
    owner_t      sel_owner;
    logic        sel_we, sel_legal;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;

`ifdef RAM_ARB_ACCESS_CHECK_EN
    ram_arb_access_check #(.RAM_WORDS(RAM_WORDS)) u_chk0 (
        .size_i  (m0_size),
        .addr_i  (m0_addr),
        .legal_o (legal0)
    );
    ram_arb_access_check #(.RAM_WORDS(RAM_WORDS)) u_chk1 (
        .size_i  (m1_size),
        .addr_i  (m1_addr),
        .legal_o (legal1)
    );
`else
    assign legal0 = 1'b1;
    assign legal1 = 1'b1;
`endif

    always_comb begin
        // Port 0 takes a tie when it is its turn (normal) or it has waited MAX_WAIT (boot).
        win0      = boot_active ? (wait_cnt_q == WaitMax) : (last_gnt_q == 1'b1);
        m0_gnt    = m0_req & (~m1_req | win0);
        m1_gnt    = m1_req & ~m0_gnt;
        any_gnt   = m0_gnt | m1_gnt;
        sel_owner = owner_t'(m1_gnt);
        sel_we    = sel_owner ? m1_we    : m0_we;
        sel_size  = sel_owner ? m1_size  : m0_size;
        sel_addr  = sel_owner ? m1_addr  : m0_addr;
        sel_wdata = sel_owner ? m1_wdata : m0_wdata;
        sel_legal = sel_owner ? legal1   : legal0;
        rd_gnt    = any_gnt & ~sel_we;
        drive     = any_gnt & sel_legal;
        ram_we    = drive & sel_we;
        ram_re    = drive & ~sel_we;
        ram_size  = drive ? sel_size  : 3'b000;
        ram_addr  = drive ? sel_addr  : 32'h0;
        ram_wdata = drive ? sel_wdata : 32'h0;
    end

    always_comb begin
        last_gnt_d = any_gnt ? sel_owner : last_gnt_q;
        wait_cnt_d = wait_cnt_q;
        if (!m0_req || m0_gnt) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < WaitMax) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt_q <= 1'b1;
            wait_cnt_q <= 8'd0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rd_owner_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    if (rd_gnt) state_q <= RESP;
                RESP:    if (!rd_gnt) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (rd_gnt) begin
                rd_owner_q <= sel_owner;
                rd_err_q   <= ~sel_legal;
            end
        end
    end

    assign m0_rvalid = (state_q == RESP) && (rd_owner_q == 1'b0);
    assign m1_rvalid = (state_q == RESP) && (rd_owner_q == 1'b1);
    assign m0_rdata  = (m0_rvalid && !rd_err_q) ? ram_rdata : 32'h0;
    assign m1_rdata  = (m1_rvalid && !rd_err_q) ? ram_rdata : 32'h0;

`ifdef RAM_ARB_ACCESS_CHECK_EN
    // Read errors report with the response; write errors report in the grant cycle.
    assign m0_err = (m0_rvalid & rd_err_q) | (m0_gnt & m0_we & ~legal0);
    assign m1_err = (m1_rvalid & rd_err_q) | (m1_gnt & m1_we & ~legal1);
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a small behavioural RAM.
// Define RAM_ARB_ACCESS_CHECK_EN to also exercise the access check.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        boot_active;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [2:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [2:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        ram_we, ram_re;
    logic [2:0]  ram_size;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef RAM_ARB_ACCESS_CHECK_EN
    logic        m0_err, m1_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.MAX_WAIT(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .boot_active (boot_active),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_size     (m0_size),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_size     (m1_size),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
`ifdef RAM_ARB_ACCESS_CHECK_EN
        .m0_err      (m0_err),
        .m1_err      (m1_err),
`endif
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_size    (ram_size),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Behavioural RAM: word i holds 0xA000_0000 | i after reset, registered read.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else begin
            if (ram_we) begin
                case (ram_size)
                    3'b000:  mem[ram_addr[11:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[7:0];
                    3'b001:  mem[ram_addr[11:2]][16*ram_addr[1] +: 16] <= ram_wdata[15:0];
                    default: mem[ram_addr[11:2]] <= ram_wdata;
                endcase
            end
            if (ram_re) begin
                case (ram_size)
                    3'b000:  ram_rdata <= {24'h0, mem[ram_addr[11:2]][8*ram_addr[1:0] +: 8]};
                    3'b001:  ram_rdata <= {16'h0, mem[ram_addr[11:2]][16*ram_addr[1] +: 16]};
                    default: ram_rdata <= mem[ram_addr[11:2]];
                endcase
            end
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1;
        logic [31:0] a1;
        logic        g0, g1, we, re;
        logic [31:0] addr, wd;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                                input logic r1, input logic [31:0] a1,
                                input logic g0, g1, we, re, input logic [31:0] addr, wd,
                                input logic rv0, rv1, input logic [31:0] rd0, rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.re = re; v.addr = addr; v.wd = wd;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of requests just after the edge, then settle to the falling edge.
    task automatic cyc(input logic r0, w0, input logic [2:0] s0, input logic [31:0] a0, d0,
                       input logic r1, input logic [31:0] a1, input logic bt);
        @(posedge clk);
        #1;
        m0_req = r0; m0_we = w0; m0_size = s0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = 1'b0; m1_size = 3'b010; m1_addr = a1; m1_wdata = 32'h0;
        boot_active = bt;
        @(negedge clk);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = mk(0, 0, 0,     0,            0, 0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 0);
        vecs[1] = mk(1, 0, 'h10,  0,            1, 'h20,  1, 0, 0, 1, 'h10,  0,            0, 0, 0, 0);
        vecs[2] = mk(0, 0, 0,     0,            1, 'h20,  0, 1, 0, 1, 'h20,  0,            1, 0, 'hA0000004, 0);
        vecs[3] = mk(1, 0, 'h10,  0,            1, 'h20,  1, 0, 0, 1, 'h10,  0,            0, 1, 0, 'hA0000008);
        vecs[4] = mk(1, 0, 'h10,  0,            1, 'h20,  0, 1, 0, 1, 'h20,  0,            1, 0, 'hA0000004, 0);
        vecs[5] = mk(1, 1, 'h30,  'h12345678,   1, 'h20,  1, 0, 1, 0, 'h30,  'h12345678,   0, 1, 0, 'hA0000008);
        vecs[6] = mk(0, 0, 0,     0,            1, 'h20,  0, 1, 0, 1, 'h20,  0,            0, 0, 0, 0);
        vecs[7] = mk(1, 0, 'h30,  0,            0, 0,     1, 0, 0, 1, 'h30,  0,            0, 1, 0, 'hA0000008);
        vecs[8] = mk(0, 0, 0,     0,            0, 0,     0, 0, 0, 0, 0,     0,            1, 0, 'h12345678, 0);

        resetn = 1'b0; boot_active = 1'b0;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rdata1", m1_rdata, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Normal-mode round robin, write-then-read and response routing.
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].r0, vecs[i].w0, 3'b010, vecs[i].a0, vecs[i].d0, vecs[i].r1, vecs[i].a1, 0);
            chk($sformatf("v%0d_gnt", i), {m0_gnt, m1_gnt}, {vecs[i].g0, vecs[i].g1});
            chk($sformatf("v%0d_we_re", i), {ram_we, ram_re}, {vecs[i].we, vecs[i].re});
            chk($sformatf("v%0d_size", i), ram_size, (vecs[i].g0 | vecs[i].g1) ? 3'b010 : 3'b000);
            chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].wd);
            chk($sformatf("v%0d_rvalid", i), {m0_rvalid, m1_rvalid}, {vecs[i].rv0, vecs[i].rv1});
            chk($sformatf("v%0d_rdata0", i), m0_rdata, vecs[i].rd0);
            chk($sformatf("v%0d_rdata1", i), m1_rdata, vecs[i].rd1);
        end

        // Boot mode with MAX_WAIT=3: port 1 three times, then port 0 once.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 3'b010, 'h10, 0, 1, 'h20, 1);
            chk($sformatf("boot%0d_gnt", i), {m0_gnt, m1_gnt},
                (i % 4 == 3) ? 2'b10 : 2'b01);
        end
        cyc(0, 0, 3'b010, 0, 0, 0, 0, 0);

        // Byte write into the top lane, then word read of the same word.
        cyc(1, 1, 3'b000, 'h103, 'hA5, 0, 0, 0);
        chk("bw_gnt", m0_gnt, 1);
        chk("bw_ram", {ram_we, ram_re, ram_size}, {2'b10, 3'b000});
        chk("bw_addr", ram_addr, 'h103);
        cyc(1, 0, 3'b010, 'h100, 0, 0, 0, 0);
        chk("br_re", ram_re, 1);
        cyc(0, 0, 3'b010, 0, 0, 0, 0, 0);
        chk("br_rvalid", m0_rvalid, 1);
        chk("br_rdata", m0_rdata, 'hA500_0040);

        // Port 1 read then port 0 read: responses stay with their owners.
        cyc(0, 0, 3'b010, 0, 0, 1, 'h20, 0);
        chk("x_gnt1", m1_gnt, 1);
        cyc(1, 0, 3'b010, 'h10, 0, 0, 0, 0);
        chk("x_gnt0", m0_gnt, 1);
        chk("x_rv_n1", {m0_rvalid, m1_rvalid}, 2'b01);
        chk("x_rd1_n1", m1_rdata, 'hA000_0008);
        chk("x_rd0_n1", m0_rdata, 0);
        cyc(0, 0, 3'b010, 0, 0, 0, 0, 0);
        chk("x_rv_n2", {m0_rvalid, m1_rvalid}, 2'b10);
        chk("x_rd0_n2", m0_rdata, 'hA000_0004);
        chk("x_rd1_n2", m1_rdata, 0);

`ifdef RAM_ARB_ACCESS_CHECK_EN
        cyc(1, 0, 3'b010, 'h102, 0, 0, 0, 0);
        chk("mis_gnt", m0_gnt, 1);
        chk("mis_re", {ram_re, ram_we}, 0);
        chk("mis_err_g", m0_err, 0);
        cyc(1, 1, 3'b011, 'h40, 'h55, 0, 0, 0);
        chk("mis_rv", m0_rvalid, 1);
        chk("mis_err", m0_err, 1);
        chk("mis_rdata", m0_rdata, 0);
        chk("bsz_gnt", m0_gnt, 1);
        chk("bsz_we", ram_we, 0);
        cyc(0, 0, 3'b010, 0, 0, 1, 32'(8001 * 4), 0);
        chk("bsz_err_clr", m0_err, 0);
        chk("oor_gnt", m1_gnt, 1);
        chk("oor_re", ram_re, 0);
        cyc(0, 0, 3'b010, 0, 0, 0, 0, 0);
        chk("oor_err", {m1_rvalid, m1_err}, 2'b11);
        chk("oor_rdata", m1_rdata, 0);
`endif

        // Reset right after a read grant discards the response asynchronously.
        cyc(1, 0, 3'b010, 'h10, 0, 0, 0, 0);
        chk("rr_gnt", m0_gnt, 1);
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rr_async_rv", {m0_rvalid, m1_rvalid}, 0);
        chk("rr_async_rd", m0_rdata, 0);
        chk("rr_async_ram", {ram_we, ram_re, m0_gnt, m1_gnt}, 0);
        chk("rr_async_addr", ram_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rr_hold_rv", m0_rvalid, 0);
        #1 resetn = 1'b1;
        cyc(1, 0, 3'b010, 'h10, 0, 1, 'h20, 0);
        chk("rr_first_tie", {m0_gnt, m1_gnt}, 2'b10);
        cyc(0, 0, 3'b010, 0, 0, 0, 0, 0);
        chk("rr_after_rd", m0_rdata, 'hA000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
